// File: rtl/vector_delay_ctrl_if.sv
// Control/status bundle between the vector datapath sequencer and its host.
// The host drives enable/start/job size. The controller returns state, counters and RAM strobes.
interface vector_delay_ctrl_if #(
  parameter int RAM_ADDR_WIDTH = 7
);
  logic                      enable;
  logic                      start;
  logic [RAM_ADDR_WIDTH-1:0] num_lines;
  logic [RAM_ADDR_WIDTH-1:0] comp_cycle;

  logic [2:0]                STATE;
  logic [RAM_ADDR_WIDTH+1:0] master_cnt;
  logic                      fix_next_state;
  logic                      ram_wr_en;
  logic                      ram_rd_en;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      busy;
  logic                      done;

  modport master (
    output enable, start, num_lines, comp_cycle,
    input  STATE, master_cnt, fix_next_state, ram_wr_en, ram_rd_en, ram_addr, busy, done
  );

  modport slave (
    input  enable, start, num_lines, comp_cycle,
    output STATE, master_cnt, fix_next_state, ram_wr_en, ram_rd_en, ram_addr, busy, done
  );
endinterface

// File: rtl/vector_delay_ctrl.sv
// Sequencer for the unrolled online-arithmetic vector delay/select stage.
// A single start pulse runs one complete job. The job first writes every line into the line RAM.
// It then reads each line back for L = comp_cycle*UNROLLING cycles.
//
//   state              | meaning
//   -------------------+--------------------------------------------------------
//   START              | idle, counters 0, waiting for start & enable
//   WRITE_IN           | one line-RAM write per enabled cycle, addr = line_cnt
//   READ_OUT           | reading lines 0..n-2, master_cnt sweeps 0..L-1 per line
//   READ_OUT_LAST_LINE | reading line n-1
//   END                | done pulse, returns to START
module vector_delay_ctrl #(
  parameter int         UNROLLING          = 4,
  parameter int         RAM_ADDR_WIDTH     = 7,
  parameter logic [2:0] START              = 3'd0,
  parameter logic [2:0] WRITE_IN           = 3'd1,
  parameter logic [2:0] READ_OUT           = 3'd2,
  parameter logic [2:0] READ_OUT_LAST_LINE = 3'd3,
  parameter logic [2:0] END                = 3'd4
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  vector_delay_ctrl_if.slave   bus
);

  localparam int AW      = RAM_ADDR_WIDTH;
  localparam int MW      = RAM_ADDR_WIDTH + 2;
  localparam int U_SHIFT = $clog2(UNROLLING);

  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [MW-1:0] M_ONE = MW'(1);

  typedef enum logic [2:0] {
    S_START     = START,
    S_WRITE_IN  = WRITE_IN,
    S_READ_OUT  = READ_OUT,
    S_READ_LAST = READ_OUT_LAST_LINE,
    S_END       = END
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   n_lat_q, n_lat_d;
  logic [AW-1:0]   c_lat_q, c_lat_d;
  logic [AW-1:0]   line_cnt_q, line_cnt_d;
  logic [MW-1:0]   master_cnt_q, master_cnt_d;
  logic            fix_q, fix_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [MW-1:0]   l_len;
  logic [AW-1:0]   n_last;
  logic            master_last;

  // Line length is a power of two multiple of comp_cycle, so a shift is enough.
  assign l_len       = {2'b00, c_lat_q} << U_SHIFT;
  assign n_last      = n_lat_q - A_ONE;
  assign master_last = (master_cnt_q == (l_len - M_ONE));

  // Next-state and counter update; nothing moves while enable is low.
  always_comb begin
    state_d      = state_q;
    n_lat_d      = n_lat_q;
    c_lat_d      = c_lat_q;
    line_cnt_d   = line_cnt_q;
    master_cnt_d = master_cnt_q;

    if (bus.enable) begin
      case (state_q)
        S_START: begin
          if (bus.start) begin
            n_lat_d      = (bus.num_lines  == '0) ? A_ONE : bus.num_lines;
            c_lat_d      = (bus.comp_cycle == '0) ? A_ONE : bus.comp_cycle;
            line_cnt_d   = '0;
            master_cnt_d = '0;
            state_d      = S_WRITE_IN;
          end
        end
        S_WRITE_IN: begin
          if (line_cnt_q == n_last) begin
            line_cnt_d = '0;
            state_d    = (n_lat_q > A_ONE) ? S_READ_OUT : S_READ_LAST;
          end else begin
            line_cnt_d = line_cnt_q + A_ONE;
          end
        end
        S_READ_OUT: begin
          if (master_last) begin
            master_cnt_d = '0;
            line_cnt_d   = line_cnt_q + A_ONE;
            if ((line_cnt_q + A_ONE) == n_last) state_d = S_READ_LAST;
          end else begin
            master_cnt_d = master_cnt_q + M_ONE;
          end
        end
        S_READ_LAST: begin
          if (master_last) begin
            master_cnt_d = '0;
            line_cnt_d   = '0;
            state_d      = S_END;
          end else begin
            master_cnt_d = master_cnt_q + M_ONE;
          end
        end
        S_END: begin
          state_d = S_START;
        end
        default: begin
          state_d      = S_START;
          line_cnt_d   = '0;
          master_cnt_d = '0;
        end
      endcase
    end
  end

  // Registered status flags are derived from the next state so they line up with STATE.
  always_comb begin
    fix_d  = ((state_d == S_READ_OUT) || (state_d == S_READ_LAST)) && (master_cnt_d == '0);
    busy_d = (state_d != S_START);
    done_d = (state_d == S_END);
  end

  // State, latched job size, counters and status flags.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q      <= S_START;
      n_lat_q      <= '0;
      c_lat_q      <= '0;
      line_cnt_q   <= '0;
      master_cnt_q <= '0;
      fix_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_lat_q      <= n_lat_d;
      c_lat_q      <= c_lat_d;
      line_cnt_q   <= line_cnt_d;
      master_cnt_q <= master_cnt_d;
      fix_q        <= fix_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.STATE          = state_q;
  assign bus.master_cnt     = master_cnt_q;
  assign bus.fix_next_state = fix_q;
  assign bus.ram_addr       = line_cnt_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  // Strobes are the only combinational outputs. A stalled cycle must not touch the RAM.
  assign bus.ram_wr_en      = bus.enable && (state_q == S_WRITE_IN);
  assign bus.ram_rd_en      = bus.enable && ((state_q == S_READ_OUT) || (state_q == S_READ_LAST));

endmodule

// File: tb/tb_vector_delay_ctrl.sv
`timescale 1ns/1ps
module tb_vector_delay_ctrl;
  localparam int AW = 7;
  localparam logic [2:0] ST_WR = 3'd1, ST_RO = 3'd2, ST_RL = 3'd3, ST_END = 3'd4;

  typedef struct packed {
    logic [2:0]    st;
    logic [AW+1:0] mc;
    logic [AW-1:0] addr;
    logic          fix;
    logic          wr;
    logic          rd;
    logic          busy;
    logic          done;
  } obs_t;

  logic clk = 1'b0;
  logic asyn_reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  vector_delay_ctrl_if #(.RAM_ADDR_WIDTH(AW)) vif();

  vector_delay_ctrl #(.UNROLLING(4), .RAM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (vif.slave)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.st   = vif.STATE;
    o.mc   = vif.master_cnt;
    o.addr = vif.ram_addr;
    o.fix  = vif.fix_next_state;
    o.wr   = vif.ram_wr_en;
    o.rd   = vif.ram_rd_en;
    o.busy = vif.busy;
    o.done = vif.done;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s t=%0t got st=%0d mc=%0d addr=%0d fix=%b wr=%b rd=%b busy=%b done=%b required st=%0d mc=%0d addr=%0d fix=%b wr=%b rd=%b busy=%b done=%b",
                 name, $time, act.st, act.mc, act.addr, act.fix, act.wr, act.rd, act.busy, act.done,
                 req.st, req.mc, req.addr, req.fix, req.wr, req.rd, req.busy, req.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, req);
    end
  endtask

  // Reference model: the full per-cycle schedule of one job, built from the job rules.
  task automatic push_job(input int n, input int c);
    int   nn, cc, l;
    obs_t e;
    nn = (n == 0) ? 1 : n;
    cc = (c == 0) ? 1 : c;
    l  = cc * 4;
    for (int i = 0; i < nn; i++) begin
      e = '0; e.st = ST_WR; e.addr = AW'(i); e.wr = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    for (int ln = 0; ln < nn; ln++) begin
      for (int m = 0; m < l; m++) begin
        e = '0;
        e.st   = (ln == nn - 1) ? ST_RL : ST_RO;
        e.mc   = (AW+2)'(m);
        e.addr = AW'(ln);
        e.fix  = (m == 0);
        e.rd   = 1'b1;
        e.busy = 1'b1;
        exp_q.push_back(e);
      end
    end
    e = '0; e.st = ST_END; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT must show the head of the schedule, or idle when none is pending.
  always @(negedge clk) begin
    obs_t e;
    logic en;
    en = vif.enable;
    if (exp_q.size() > 0) e = exp_q[0];
    else e = '0;
    if (en !== 1'b1) begin
      e.wr = 1'b0;
      e.rd = 1'b0;
    end
    check_obs("cycle", observe(), e);
    if (exp_q.size() > 0 && en === 1'b1 && !asyn_reset) void'(exp_q.pop_front());
  end

  // Called at posedge+1: asserts reset mid-cycle, checks immediate clear, releases before the next edge.
  task automatic mid_reset();
    obs_t z;
    z = '0;
    #1 asyn_reset = 1'b1;
    exp_q.delete();
    #1 check_obs("reset_async", observe(), z);
    #4 asyn_reset = 1'b0;
    @(posedge clk); #1;
    vif.start  = 1'b0;
    vif.enable = 1'b1;
  endtask

  task automatic run_job(input int n, input int c, input int stall_pct, input int stall_at,
                         input int stall_len, input int mid_start_at, input int abort_after);
    int   cyc, stalls, exp_len, budget, nn, cc;
    logic en;
    nn = (n == 0) ? 1 : n;
    cc = (c == 0) ? 1 : c;
    exp_len = nn + nn * cc * 4 + 1;
    vif.num_lines  = AW'(n);
    vif.comp_cycle = AW'(c);
    vif.start  = 1'b1;
    vif.enable = 1'b1;
    @(posedge clk);
    push_job(n, c);
    #1;
    vif.start      = 1'b0;
    vif.num_lines  = AW'($urandom);
    vif.comp_cycle = AW'($urandom);
    cyc = 0; stalls = 0; budget = 2 * exp_len + 50;
    while (vif.busy === 1'b1 && cyc < budget) begin
      if (cyc == abort_after) begin
        mid_reset();
        return;
      end
      if (cyc >= stall_at && cyc < stall_at + stall_len) en = 1'b0;
      else en = ($urandom_range(99) >= stall_pct);
      vif.enable = en;
      if (!en) stalls++;
      vif.start = (cyc == mid_start_at);
      @(posedge clk); #1;
      cyc++;
    end
    vif.start  = 1'b0;
    vif.enable = 1'b1;
    check_int("job_len", cyc, exp_len + stalls);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no finish required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t z;
    z = '0;
    vif.enable     = 1'b1;
    vif.start      = 1'b0;
    vif.num_lines  = '0;
    vif.comp_cycle = '0;

    #2 asyn_reset = 1'b1;
    #1 check_obs("reset_initial", observe(), z);
    @(posedge clk);
    @(posedge clk);
    #3 asyn_reset = 1'b0;
    @(posedge clk); #1;

    repeat (5) begin @(posedge clk); #1; end
    check_int("idle_state", int'(vif.STATE), 0);
    check_int("idle_busy", int'(vif.busy), 0);

    vif.start  = 1'b1;
    vif.enable = 1'b0;
    vif.num_lines = AW'(3);
    repeat (3) begin @(posedge clk); #1; end
    check_int("start_gated_by_enable", int'(vif.busy), 0);
    vif.start  = 1'b0;
    vif.enable = 1'b1;

    run_job(3, 2, 0, -1, 0, 12, -1);
    run_job(1, 1, 0, -1, 0, -1, -1);
    run_job(0, 0, 0, -1, 0, -1, -1);
    run_job(3, 2, 0, 16, 5, -1, -1);
    run_job(3, 2, 0, -1, 0, -1, 14);
    check_int("after_abort_state", int'(vif.STATE), 0);
    run_job(3, 2, 0, -1, 0, -1, -1);

    for (int k = 0; k < 25; k++) begin
      run_job(int'($urandom_range(9)), int'($urandom_range(4)), 15, -1, 0,
              int'($urandom_range(30)), -1);
      repeat (int'($urandom_range(2))) begin @(posedge clk); #1; end
    end
    run_job(127, 1, 10, -1, 0, 40, -1);
    run_job(2, 127, 5, -1, 0, -1, -1);
    run_job(1, 127, 0, -1, 0, -1, -1);

    repeat (3) begin @(posedge clk); #1; end
    check_int("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_delay_ctrl.md
# vector_delay_ctrl

Sequencing controller for the unrolled online-arithmetic vector datapath. It generates `STATE`, `master_cnt` and `fix_next_state` for the vector delay/select stage, and drives the line-RAM write/read strobes and address. One `start` pulse runs a complete job: a write-in phase, then a per-line read-out phase ending with a dedicated last-line state.

## Interface
- UNROLLING, 4: digits per cycle. Line length is `comp_cycle*UNROLLING`; must be a power of two, and the multiply is implemented as a shift.
- RAM_ADDR_WIDTH, 7: line-RAM address width.
- START/WRITE_IN/READ_OUT/READ_OUT_LAST_LINE/END, 3'd0/1/2/3/4: state encodings.
- clk  in  1  clock; all logic on rising edge.
- asyn_reset  in  1  reset, asynchronous, active-high.
- enable  in  1  global advance; when 0 every register holds.
- start  in  1  job request; sampled only in START with enable=1.
- num_lines  in  RAM_ADDR_WIDTH  lines per job; 0 treated as 1; latched on start.
- comp_cycle  in  RAM_ADDR_WIDTH  compute cycles per line; 0 treated as 1; latched on start.
- STATE  out  3  current state (registered).
- master_cnt  out  RAM_ADDR_WIDTH+2  cycle index within current read line (registered).
- fix_next_state  out  1  one-cycle flag on first cycle of each read line.
- ram_wr_en  out  1  line-RAM write strobe.
- ram_rd_en  out  1  line-RAM read strobe.
- ram_addr  out  RAM_ADDR_WIDTH  line-RAM address (= line counter).
- busy  out  1  STATE != START.
- done  out  1  one-cycle pulse while in END.

## Operation
- Internal registers:
  - `n_lat` and `c_lat`: latched `num_lines` and `comp_cycle`, with 0 mapped to 1.
  - `line_cnt`: width RAM_ADDR_WIDTH.
  - `L = c_lat*UNROLLING`: width RAM_ADDR_WIDTH+2, no overflow possible.
- START: counters are 0. On `start & enable`, latch the inputs, clear `line_cnt` and `master_cnt`, and go to WRITE_IN.
- WRITE_IN: `ram_wr_en=enable`, `ram_addr=line_cnt`.
  - `line_cnt` increments on each enabled cycle.
  - When `line_cnt==n_lat-1`: clear `line_cnt`, then go to READ_OUT if `n_lat>1`, else to READ_OUT_LAST_LINE.
- READ_OUT: `ram_rd_en=enable`, `ram_addr=line_cnt`.
  - `master_cnt` increments on each enabled cycle.
  - When `master_cnt==L-1`: set `master_cnt` to 0 and increment `line_cnt`. If the new `line_cnt==n_lat-1`, go to READ_OUT_LAST_LINE.
- READ_OUT_LAST_LINE: same counting as READ_OUT. When `master_cnt==L-1`, go to END with `master_cnt` and `line_cnt` cleared.
- END: `done=1` for one cycle, then go to START unconditionally; `start` is ignored in END.
- fix_next_state: 1 when STATE is READ_OUT or READ_OUT_LAST_LINE and `master_cnt==0`.
- `start` is ignored outside START. `num_lines`/`comp_cycle` changes mid-job have no effect.
- `ram_wr_en`/`ram_rd_en` are gated by `enable`; all other outputs are registered and hold while `enable=0`.
- Reset, mid-job included: immediately STATE=START; `master_cnt`, `line_cnt`, `ram_addr`, `fix_next_state`, `ram_wr_en`, `ram_rd_en`, `busy` and `done` all 0; latched values 0.

## Timing
- Start latency: `start` accepted at edge k puts STATE=WRITE_IN from cycle k+1.
- Job length with `enable` held high: N cycles WRITE_IN + (N-1)·L cycles READ_OUT + L cycles READ_OUT_LAST_LINE + 1 cycle END. Back in START on the next cycle.
- `ram_addr` is valid in the same cycle as its strobe. Read data returns one cycle later, matching the one-cycle delay in the select stage.
- An `enable=0` cycle stretches the schedule by exactly one cycle. No counter advances and no strobe is asserted during it.
- `master_cnt` wraps to 0 only at `L-1`; it never reaches `L`.
- `line_cnt` never exceeds `n_lat-1`.

## Test plan
- Reset values: assert `asyn_reset` mid-cycle -> all outputs 0 and STATE=0 before the next edge. Release, hold `start=0` -> STATE stays 0 and `busy=0`.
- Nominal run, num_lines=3, comp_cycle=2, enable=1 (L=8):
  - WRITE_IN for 3 cycles, `ram_addr` 0,1,2.
  - READ_OUT for 16 cycles, `ram_addr` 0 then 1.
  - READ_OUT_LAST_LINE for 8 cycles, `ram_addr` 2.
  - END for 1 cycle with `done=1`.
  - `fix_next_state` high exactly 3 times.
- Single line, num_lines=1, comp_cycle=1: WRITE_IN 1 cycle, then READ_OUT_LAST_LINE 4 cycles (`master_cnt` 0..3), then END. READ_OUT never entered.
- Zero inputs, num_lines=0, comp_cycle=0 -> behaves identically to the num_lines=1, comp_cycle=1 case.
- Stall: nominal run with `enable=0` for 5 cycles at `master_cnt=5` of line 1 -> counters frozen, `ram_rd_en=0`; total job length +5.
- Mid-job changes: change `num_lines` and pulse `start` during READ_OUT -> schedule unchanged. Then reset during READ_OUT -> immediate START with all outputs 0; a fresh `start` then runs a full job.
